// File: rtl/fp_add_pkg.sv
// Shared types and constants for the shared fp32 adder arbiter.
// Tag entries are sized for the widest supported requester count, which is 8.
package fp_add_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam int TAG_MAX_W = 3;

  function automatic int tag_w(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  typedef struct packed {
    logic                 vld;
    logic [TAG_MAX_W-1:0] tag;
  } tag_ent_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
// The grant is one-hot, or zero when en is low or nothing is valid.
module rr_arbiter
  import fp_add_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int TW   = tag_w(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [TW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [TW-1:0]   gnt_idx
);
  logic hit;

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    hit     = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (valid[idx]) begin
        hit     = 1'b1;
        gnt_idx = TW'(idx);
      end
    end
  end

  assign gnt = (hit && en) ? (NREQ'(1) << gnt_idx) : '0;
endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one external fp adder among NREQ requesters.
// A tag pipe matched to the adder latency routes each sum back to the requester that issued it.
module fp_add_arbiter
  import fp_add_pkg::*;
#(
  parameter int N       = FP_W,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [N-1:0]     rsp_data,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  input  logic [N-1:0]     add_c,
  input  logic             halt,
  output logic             idle,
  output logic [3:0]       inflight
);
  localparam int TW = tag_w(NREQ);

  logic [TW-1:0]   rr_ptr;
  logic [TW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            xfer;
  tag_ent_t        tag_pipe [ADD_LAT:0];
  tag_ent_t        last;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid   (req_valid),
    .ptr     (rr_ptr),
    .en      (~halt),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);
  assign last      = tag_pipe[ADD_LAT];
  assign idle      = (inflight == 4'd0) && !xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      inflight  <= '0;
      for (int s = 0; s <= ADD_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      if (xfer) begin
        add_a  <= req_a[gnt_idx*N +: N];
        add_b  <= req_b[gnt_idx*N +: N];
        rr_ptr <= (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      tag_pipe[0] <= '{vld: xfer, tag: TAG_MAX_W'(gnt_idx)};
      for (int s = 1; s <= ADD_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];

      // The last stage lines up with add_c holding that operation's sum.
      rsp_valid <= last.vld ? (NREQ'(1) << last.tag) : '0;
      if (last.vld) rsp_data <= add_c;

      case ({xfer, last.vld})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a one-cycle behavioural fp32 adder on add_c.
module tb_fp_add_arbiter;
  import fp_add_pkg::*;
  localparam int NREQ = 4;
  localparam int N = 32;
  localparam int ADD_LAT = 1;

  logic clk, rst_n, halt, idle;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
  logic [NREQ*N-1:0] req_a, req_b;
  logic [N-1:0] rsp_data, add_a, add_b, add_c;
  logic [3:0] inflight;

  int n_chk = 0;
  int n_fail = 0;

  fp_add_arbiter #(.N(N), .NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .add_a(add_a), .add_b(add_b), .add_c(add_c), .halt(halt), .idle(idle),
    .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Positive-operand fp32 add, truncating; exact for the small integers used here.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  e;
    logic [24:0] mx, my, s;
    int d;
    if (a[30:0] == 31'd0) return b;
    if (b[30:0] == 31'd0) return a;
    if (a[30:23] >= b[30:23]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = int'(x[30:23]) - int'(y[30:23]);
    mx = {2'b01, x[22:0]};
    my = (d > 24) ? 25'd0 : ({2'b01, y[22:0]} >> d);
    s  = mx + my;
    e  = x[30:23];
    if (s[24]) begin s = s >> 1; e = e + 8'd1; end
    return {x[31], e, s[22:0]};
  endfunction

  always @(posedge clk) add_c <= fp_add(add_a, add_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sums2 [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
  int          inf2  [6] = '{1, 2, 2, 2, 1, 0};
  logic [31:0] a5    [5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h3F80_0000};
  logic [31:0] s5    [5] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h4000_0000};

  initial begin
    rst_n = 1'b0; halt = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    step(); step();
    chk("rst_add_a", add_a, 32'h0);
    chk("rst_add_b", add_b, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_inflight", 32'(inflight), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    rst_n = 1'b1;
    step();

    // Single request from requester 0: 1.0 + 2.0
    req_a[0*N +: N] = FP_ONE; req_b[0*N +: N] = 32'h4000_0000; req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    chk("t1_idle_busy", 32'(idle), 32'h0);
    step();
    req_valid = '0;
    chk("t1_add_a", add_a, FP_ONE);
    chk("t1_inflight1", 32'(inflight), 32'h1);
    step();
    chk("t1_no_rsp_yet", 32'(rsp_valid), 32'h0);
    step();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_data", rsp_data, 32'h4040_0000);
    chk("t1_inflight0", 32'(inflight), 32'h0);
    chk("t1_idle", 32'(idle), 32'h1);

    // Fresh pointer, then all four requesters at once: i.0 + 1.0
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = (i == 0) ? FP_ZERO : fp_add(FP_ONE, (i == 1) ? FP_ZERO : ((i == 2) ? FP_ONE : 32'h4000_0000));
      req_b[i*N +: N] = FP_ONE;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        #1;
        chk($sformatf("t2_ready%0d", k), 32'(req_ready), 32'(1) << k);
      end
      step();
      if (k < 4) req_valid[k] = 1'b0;
      chk($sformatf("t2_inflight%0d", k), 32'(inflight), 32'(inf2[k]));
      chk($sformatf("t2_rsp_valid%0d", k), 32'(rsp_valid), (k >= 2) ? (32'(1) << (k - 2)) : 32'h0);
      if (k >= 2) chk($sformatf("t2_rsp_data%0d", k), rsp_data, sums2[k-2]);
    end

    // Fairness and wrap: grant 2 leaves ptr=3; then 3 beats 0, then ptr=1
    req_valid = 4'b0100;
    #1; chk("t3_ready2", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b1001;
    #1; chk("t3_ready3", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b0001;
    #1; chk("t3_ready0", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0011;
    #1; chk("t3_ptr1", 32'(req_ready), 32'h2);
    req_valid = '0;
    step(); step(); step();
    chk("t3_drained", 32'(inflight), 32'h0);

    // halt with one op in flight and requester 1 still asking
    req_a[1*N +: N] = FP_ONE; req_b[1*N +: N] = FP_ONE; req_valid = 4'b0010;
    #1; chk("t4_ready_pre", 32'(req_ready), 32'h2);
    step();
    halt = 1'b1; req_a[1*N +: N] = 32'h4000_0000; req_b[1*N +: N] = 32'h4000_0000;
    #1;
    chk("t4_ready_halt", 32'(req_ready), 32'h0);
    chk("t4_inflight", 32'(inflight), 32'h1);
    step();
    chk("t4_ready_halt2", 32'(req_ready), 32'h0);
    step();
    chk("t4_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("t4_rsp_data", rsp_data, 32'h4000_0000);
    chk("t4_idle_halt", 32'(idle), 32'h1);
    halt = 1'b0;
    #1;
    chk("t4_ready_release", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    chk("t4_add_a", add_a, 32'h4000_0000);
    step(); step();
    chk("t4_rsp2_valid", 32'(rsp_valid), 32'h2);
    chk("t4_rsp2_data", rsp_data, 32'h4080_0000);

    // Requester 2 alone, five back-to-back operations
    req_b[2*N +: N] = FP_ONE;
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin
        req_a[2*N +: N] = a5[k]; req_valid = 4'b0100;
        #1; chk($sformatf("t5_ready%0d", k), 32'(req_ready), 32'h4);
      end
      step();
      if (k == 4) req_valid = '0;
      if (k >= 2) begin
        chk($sformatf("t5_rsp_valid%0d", k), 32'(rsp_valid), 32'h4);
        chk($sformatf("t5_rsp_data%0d", k), rsp_data, s5[k-2]);
      end
    end
    step();
    chk("t5_rsp_end", 32'(rsp_valid), 32'h0);

    // Reset with two operations in flight
    req_a[0*N +: N] = FP_ONE; req_b[0*N +: N] = FP_ONE; req_valid = 4'b0001;
    #1; chk("t6_ready0", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0010;
    #1; chk("t6_ready1", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    chk("t6_inflight2", 32'(inflight), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_inflight", 32'(inflight), 32'h0);
    chk("t6_rst_add_a", add_a, 32'h0);
    chk("t6_rst_add_b", add_b, 32'h0);
    chk("t6_rst_idle", 32'(idle), 32'h1);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6_no_rsp%0d", k), 32'(rsp_valid), 32'h0);
    end
    req_a[2*N +: N] = 32'h4040_0000; req_valid = 4'b0101;
    #1; chk("t6_ptr0", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk("t6_add_a", add_a, FP_ONE);
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
